ring_lock_ctrl: RTL
===================

// Module: ring_lock_ctrl
// PURPOSE
//  Digital wavelength-lock controller for one microring. Sweeps the ring tuning code, samples drop-port
//  photocurrent through an ADC req/valid handshake, and parks the ring on the peak-power code.
//  Sits between the microring tuning input (o_tune_code drives tuning distance) and the drop-PD ADC.
// PARAMETERS
//  TuneWidth     8     width of tuning code; sweep range 0 .. 2**TuneWidth-1
//  AdcWidth      10    width of ADC power code (unsigned)
//  TuneStep      4     sweep increment in codes (>=1)
//  SettleCycles  16    cycles waited after each tune-code change before sampling (>=1)
//  DitherPeriod  1024  LOCKED cycles between dither probes (only with RING_LOCK_DITHER_EN)
// PORTS
//  i_clk         in   1          clock
//  i_rst         in   1          synchronous, active-high reset
//  i_start       in   1          pulse: begin sweep (accepted only in IDLE, LOCKED or FAIL)
//  i_abort       in   1          pulse: abandon current operation, return to IDLE
//  i_thresh      in   AdcWidth   minimum acceptable peak power
//  o_adc_req     out  1          ADC sample request; held until i_adc_valid
//  i_adc_valid   in   1          ADC result valid (one cycle)
//  i_adc_code    in   AdcWidth   ADC power sample
//  o_tune_code   out  TuneWidth  ring tuning code
//  o_busy        out  1          high in any state except IDLE, LOCKED, FAIL
//  o_locked      out  1          ring parked on peak
//  o_fail        out  1          sweep finished with peak < i_thresh
//  o_peak_code   out  TuneWidth  tune code of best sample
//  o_peak_pwr    out  AdcWidth   best sample power
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0. Reset mid-operation aborts everything at the same edge.
//  States: IDLE, SET, SETTLE, SAMPLE, PARK, LOCKED, FAIL (+ DPROBE with dither).
//  IDLE -i_start-> SET: o_tune_code<=0, peak_pwr<=0, peak_code<=0, o_locked/o_fail<=0.
//  SET -> SETTLE: counter loads SettleCycles-1; SETTLE counts to 0 -> SAMPLE.
//  SAMPLE: o_adc_req=1 from entry until the cycle i_adc_valid=1 (inclusive). On valid:
//   if i_adc_code > peak_pwr (strict; ties keep lowest code) update peak_pwr/peak_code.
//   If o_tune_code + TuneStep > 2**TuneWidth-1 (computed TuneWidth+1 bits, no wrap) -> PARK;
//   else o_tune_code += TuneStep, -> SET.
//  i_adc_valid outside SAMPLE ignored; request never re-issued before a valid.
//  PARK: if peak_pwr >= i_thresh: o_tune_code<=peak_code, -> LOCKED (o_locked=1 next cycle);
//   else o_tune_code<=0, -> FAIL (o_fail=1). i_thresh sampled in PARK only.
//  Per-point latency = 1 + SettleCycles + ADC latency; full sweep = ceil(2**TuneWidth/TuneStep) points.
//  i_abort in any state: -> IDLE next edge, o_adc_req<=0, o_tune_code<=0, flags cleared; abort beats start.
//  i_start while o_busy ignored. i_start in LOCKED/FAIL re-sweeps from code 0.
// CONFIGURATION
//  RING_LOCK_DITHER_EN defined: in LOCKED, every DitherPeriod cycles enter DPROBE: sample at
//   c-TuneStep, c, c+TuneStep (clamped to range; each with SettleCycles settle), move c to the
//   strictly-highest sample (ties keep c), return to LOCKED; o_locked stays 1 during probe.
//   If the sample at c < i_thresh: o_locked<=0 and auto re-sweep (-> SET at code 0).
//  Not defined: LOCKED holds o_tune_code indefinitely; no DPROBE state, no period counter.
// STRUCTURE
//  wdm_pkg: ring_lock_state_e enum typedef, RING_TUNE_MAX localparam helper function.
//  Sub-module ring_peak_tracker: holds peak_pwr/peak_code, strict-greater compare, clear input;
//   reused for both sweep and dither probe. Rest (FSM, settle counter, ADC handshake) in top.
// TESTING (bench: ADC model returns Lorentzian peak 900 at code 100, floor 50, 3-cycle latency)
//  Sweep: i_thresh=500, pulse i_start -> 64 points sampled, o_tune_code=100, o_peak_pwr=900, o_locked=1.
//  Tie: model gives 900 at codes 100 and 104 -> o_peak_code=100.
//  Fail: i_thresh=950 -> o_fail=1, o_locked=0, o_tune_code=0 after last point (code 252).
//  Abort/reset: i_abort during SETTLE at code 40 -> IDLE next cycle, o_adc_req=0; repeat with i_rst
//   while o_adc_req=1 -> all outputs 0 next edge, late i_adc_valid ignored.
//  Handshake: ADC latency 0..20 random -> o_adc_req never drops before valid, one update per point.
//  Dither (RING_LOCK_DITHER_EN): shift model peak to 104 after lock -> o_tune_code=104 within one
//   probe; drop peak to 200 -> o_locked=0 and a new sweep starts.

Source files
------------

// File: rtl/wdm_pkg.sv
// Shared types and helpers for the microring wavelength-lock controller.
//   ring_lock_state_e : controller FSM states (ST_DPROBE exists only when
//                       RING_LOCK_DITHER_EN is defined)
//   ring_tune_max()   : largest tuning code for a given code width
package wdm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SET    = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_PARK   = 3'd4,
        ST_LOCKED = 3'd5,
        ST_FAIL   = 3'd6
`ifdef RING_LOCK_DITHER_EN
        ,
        ST_DPROBE = 3'd7
`endif
    } ring_lock_state_e;

    // Top of the tuning range, 2**width - 1.
    function automatic int unsigned ring_tune_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/ring_lock_ctrl_peak.sv
// ring_peak_tracker: running maximum of ADC power samples and the tuning code
// at which it was seen. Strictly-greater compare, so on equal power the
// earliest sample wins.
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_clear        zero the stored peak (takes priority over i_upd)
//   i_upd          one sample is valid this cycle
//   i_code, i_pwr  tuning code and power of that sample
//   o_peak_code    code of the best sample so far
//   o_peak_pwr     power of the best sample so far
module ring_peak_tracker #(
    parameter int unsigned TuneWidth = 8,
    parameter int unsigned AdcWidth  = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clear,
    input  logic                 i_upd,
    input  logic [TuneWidth-1:0] i_code,
    input  logic [AdcWidth-1:0]  i_pwr,
    output logic [TuneWidth-1:0] o_peak_code,
    output logic [AdcWidth-1:0]  o_peak_pwr
);

    logic [TuneWidth-1:0] r_peak_code;
    logic [AdcWidth-1:0]  r_peak_pwr;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_peak_code <= '0;
            r_peak_pwr  <= '0;
        end else if (i_upd && (i_pwr > r_peak_pwr)) begin
            r_peak_code <= i_code;
            r_peak_pwr  <= i_pwr;
        end
    end

    assign o_peak_code = r_peak_code;
    assign o_peak_pwr  = r_peak_pwr;

endmodule

// File: rtl/ring_lock_ctrl.sv
// ring_lock_ctrl: wavelength-lock controller for one microring. Sweeps the
// tuning code from 0 in TuneStep increments, settles, samples drop-port power
// through an ADC req/valid handshake, then parks on the peak-power code
// (LOCKED) or returns the code to 0 (FAIL) if the peak is below i_thresh.
// Optional feature macro RING_LOCK_DITHER_EN: periodic three-point probe
// around the locked code while LOCKED, re-sweeping if power has collapsed.
//   i_clk, i_rst               clock, synchronous active-high reset
//   i_start, i_abort           begin sweep / return to IDLE (abort wins)
//   i_thresh                   minimum acceptable peak power
//   o_adc_req, i_adc_valid,
//   i_adc_code                 ADC handshake and sample
//   o_tune_code                ring tuning code
//   o_busy, o_locked, o_fail   status
//   o_peak_code, o_peak_pwr    best sample seen
module ring_lock_ctrl
    import wdm_pkg::*;
#(
    parameter int unsigned TuneWidth    = 8,
    parameter int unsigned AdcWidth     = 10,
    parameter int unsigned TuneStep     = 4,
    parameter int unsigned SettleCycles = 16,
    parameter int unsigned DitherPeriod = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [AdcWidth-1:0]  i_thresh,
    output logic                 o_adc_req,
    input  logic                 i_adc_valid,
    input  logic [AdcWidth-1:0]  i_adc_code,
    output logic [TuneWidth-1:0] o_tune_code,
    output logic                 o_busy,
    output logic                 o_locked,
    output logic                 o_fail,
    output logic [TuneWidth-1:0] o_peak_code,
    output logic [AdcWidth-1:0]  o_peak_pwr
);

    localparam int unsigned RING_TUNE_MAX = ring_tune_max(TuneWidth);
    localparam int unsigned TW1  = TuneWidth + 1;
    localparam int unsigned CntW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam logic [CntW-1:0] SETTLE_LOAD = CntW'(SettleCycles - 1);
    localparam logic [TW1-1:0]  STEP_X      = TW1'(TuneStep);
    localparam logic [TW1-1:0]  MAX_X       = TW1'(RING_TUNE_MAX);

    ring_lock_state_e     r_state;
    logic [CntW-1:0]      r_settle_cnt;
    logic                 r_adc_req;
    logic [TuneWidth-1:0] r_tune_code;
    logic                 r_busy;
    logic                 r_locked;
    logic                 r_fail;

    logic [TW1-1:0]       w_next_code;
    logic                 w_last;
    logic                 w_start;
    logic                 w_upd;
    logic                 w_clear;
    logic [TuneWidth-1:0] w_peak_code;
    logic [AdcWidth-1:0]  w_peak_pwr;

    // Next sweep point computed one bit wider so the end of range never wraps.
    assign w_next_code = {1'b0, r_tune_code} + STEP_X;
    assign w_last      = (w_next_code > MAX_X);

    assign w_start = i_start && (r_state inside {ST_IDLE, ST_LOCKED, ST_FAIL});
    assign w_upd   = !i_abort && (r_state == ST_SAMPLE) && i_adc_valid;

`ifdef RING_LOCK_DITHER_EN
    localparam int unsigned PerW = (DitherPeriod > 1) ? $clog2(DitherPeriod) : 1;

    logic                 r_probe;
    logic [1:0]           r_dphase;
    logic [TuneWidth-1:0] r_dcenter;
    logic [PerW-1:0]      r_period_cnt;
    logic [TW1-1:0]       w_dhi_x;
    logic [TuneWidth-1:0] w_dlo;
    logic [TuneWidth-1:0] w_dhi;
    logic                 w_probe_drop;

    // Probe neighbours clamped to the tuning range.
    assign w_dhi_x = {1'b0, r_dcenter} + STEP_X;
    assign w_dhi   = (w_dhi_x > MAX_X) ? TuneWidth'(RING_TUNE_MAX) : w_dhi_x[TuneWidth-1:0];
    assign w_dlo   = ({1'b0, r_dcenter} >= STEP_X) ? (r_dcenter - STEP_X[TuneWidth-1:0])
                                                   : '0;

    // Centre sample of a probe below threshold: lock is lost.
    assign w_probe_drop = r_probe && (r_dphase == 2'd0) && (i_adc_code < i_thresh);

    // Tracker restarts on a sweep start, at each probe, and on lock loss.
    assign w_clear = !i_abort &&
                     (w_start ||
                      ((r_state == ST_DPROBE) && (r_dphase != 2'd3)) ||
                      (w_upd && w_probe_drop));
`else
    assign w_clear = !i_abort && w_start;
`endif

    ring_peak_tracker #(
        .TuneWidth (TuneWidth),
        .AdcWidth  (AdcWidth)
    ) u_peak (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (w_clear),
        .i_upd       (w_upd),
        .i_code      (r_tune_code),
        .i_pwr       (i_adc_code),
        .o_peak_code (w_peak_code),
        .o_peak_pwr  (w_peak_pwr)
    );

    // Controller FSM with settle counter and ADC handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_adc_req    <= 1'b0;
            r_tune_code  <= '0;
            r_busy       <= 1'b0;
            r_locked     <= 1'b0;
            r_fail       <= 1'b0;
`ifdef RING_LOCK_DITHER_EN
            r_probe      <= 1'b0;
            r_dphase     <= '0;
            r_dcenter    <= '0;
            r_period_cnt <= '0;
`endif
        end else if (i_abort) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_adc_req    <= 1'b0;
            r_tune_code  <= '0;
            r_busy       <= 1'b0;
            r_locked     <= 1'b0;
            r_fail       <= 1'b0;
`ifdef RING_LOCK_DITHER_EN
            r_probe      <= 1'b0;
            r_period_cnt <= '0;
`endif
        end else if (w_start) begin
            r_state     <= ST_SET;
            r_adc_req   <= 1'b0;
            r_tune_code <= '0;
            r_busy      <= 1'b1;
            r_locked    <= 1'b0;
            r_fail      <= 1'b0;
`ifdef RING_LOCK_DITHER_EN
            r_probe     <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_SET: begin
                    r_settle_cnt <= SETTLE_LOAD;
                    r_state      <= ST_SETTLE;
                end

                ST_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_adc_req <= 1'b1;
                        r_state   <= ST_SAMPLE;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - CntW'(1);
                    end
                end

                ST_SAMPLE: begin
                    if (i_adc_valid) begin
                        r_adc_req <= 1'b0;
`ifdef RING_LOCK_DITHER_EN
                        if (r_probe) begin
                            case (r_dphase)
                                2'd0: begin
                                    if (w_probe_drop) begin
                                        r_probe     <= 1'b0;
                                        r_locked    <= 1'b0;
                                        r_tune_code <= '0;
                                    end else begin
                                        r_tune_code <= w_dlo;
                                        r_dphase    <= 2'd1;
                                    end
                                    r_state <= ST_SET;
                                end
                                2'd1: begin
                                    r_tune_code <= w_dhi;
                                    r_dphase    <= 2'd2;
                                    r_state     <= ST_SET;
                                end
                                default: begin
                                    // Tracker sees the last sample this edge; decide next cycle.
                                    r_dphase <= 2'd3;
                                    r_state  <= ST_DPROBE;
                                end
                            endcase
                        end else
`endif
                        if (w_last) begin
                            r_state <= ST_PARK;
                        end else begin
                            r_tune_code <= w_next_code[TuneWidth-1:0];
                            r_state     <= ST_SET;
                        end
                    end
                end

                ST_PARK: begin
                    r_busy <= 1'b0;
                    if (w_peak_pwr >= i_thresh) begin
                        r_tune_code <= w_peak_code;
                        r_locked    <= 1'b1;
                        r_state     <= ST_LOCKED;
`ifdef RING_LOCK_DITHER_EN
                        r_period_cnt <= '0;
`endif
                    end else begin
                        r_tune_code <= '0;
                        r_fail      <= 1'b1;
                        r_state     <= ST_FAIL;
                    end
                end

`ifdef RING_LOCK_DITHER_EN
                ST_LOCKED: begin
                    if (r_period_cnt == PerW'(DitherPeriod - 1)) begin
                        r_period_cnt <= '0;
                        r_dphase     <= 2'd0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_DPROBE;
                    end else begin
                        r_period_cnt <= r_period_cnt + PerW'(1);
                    end
                end

                ST_DPROBE: begin
                    if (r_dphase == 2'd3) begin
                        // Ties were resolved in favour of the centre by sampling it first.
                        r_tune_code  <= w_peak_code;
                        r_probe      <= 1'b0;
                        r_busy       <= 1'b0;
                        r_period_cnt <= '0;
                        r_state      <= ST_LOCKED;
                    end else begin
                        r_probe   <= 1'b1;
                        r_dcenter <= r_tune_code;
                        r_state   <= ST_SET;
                    end
                end
`endif

                default: ;
            endcase
        end
    end

    assign o_adc_req   = r_adc_req;
    assign o_tune_code = r_tune_code;
    assign o_busy      = r_busy;
    assign o_locked    = r_locked;
    assign o_fail      = r_fail;
    assign o_peak_code = w_peak_code;
    assign o_peak_pwr  = w_peak_pwr;

endmodule
